// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: shares the register bank's single write port among the
// ALU (req 0), load unit (req 1) and mul/div unit (req 2) write-back sources.
// Grants are combinational, and the winning write is registered onto the bank.
// It also flags read-after-write hazards for decode's two source registers.
// Build option: define WB_ARB_RR_EN for round-robin arbitration. When it is
// left undefined, arbitration is fixed priority: 1 > 0 > 2.
module wb_write_arbiter #(
    parameter int unsigned NUM_REQ      = 3,
    parameter int unsigned WORD_LEN     = 32,
    parameter int unsigned REG_ADDR_LEN = 5
) (
    input  logic                             CLK,
    input  logic                             RESET,
    input  logic [NUM_REQ-1:0]               REQ_VALID,
    input  logic [NUM_REQ*REG_ADDR_LEN-1:0]  REQ_ADDR,
    input  logic [NUM_REQ*WORD_LEN-1:0]      REQ_DATA,
    output logic [NUM_REQ-1:0]               REQ_READY,
    input  logic [REG_ADDR_LEN-1:0]          SOURCE_REG1,
    input  logic [REG_ADDR_LEN-1:0]          SOURCE_REG2,
    output logic                             WRITE_ENABLE,
    output logic [REG_ADDR_LEN-1:0]          DESTINATION_REG,
    output logic [WORD_LEN-1:0]              DATA_IN,
    output logic                             HAZARD1,
    output logic                             HAZARD2
);

    logic [NUM_REQ-1:0]      grant;
    logic                    we_q, we_d;
    logic [REG_ADDR_LEN-1:0] dest_q, dest_d;
    logic [WORD_LEN-1:0]     data_q, data_d;
    logic [REG_ADDR_LEN-1:0] win_addr;
    logic [WORD_LEN-1:0]     win_data;
    logic                    match1, match2;

`ifdef WB_ARB_RR_EN
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] cand [3];
    logic       found;

    function automatic logic [1:0] next_idx(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Round-robin search from the pointer: p, p+1, p+2 (mod 3)
    always_comb begin
        grant   = '0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        cand[0] = ptr_q;
        cand[1] = next_idx(ptr_q);
        cand[2] = next_idx(cand[1]);
        for (int unsigned k = 0; k < 3; k++) begin
            if (!found && !RESET && REQ_VALID[cand[k]]) begin
                found          = 1'b1;
                grant[cand[k]] = 1'b1;
                ptr_d          = next_idx(cand[k]);
            end
        end
    end

    // Pointer advances past the winner; held when nothing is granted
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end
`else
    // Fixed priority: load data first, then ALU, then mul/div
    always_comb begin
        grant = '0;
        if (!RESET) begin
            if (REQ_VALID[1])      grant[1] = 1'b1;
            else if (REQ_VALID[0]) grant[0] = 1'b1;
            else if (REQ_VALID[2]) grant[2] = 1'b1;
        end
    end
`endif

    assign REQ_READY = grant;

    // Select the granted requester's address and data (grant is one-hot)
    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_addr = REQ_ADDR[i*REG_ADDR_LEN +: REG_ADDR_LEN];
                win_data = REQ_DATA[i*WORD_LEN +: WORD_LEN];
            end
        end
    end

    // Next output-register value: a $zero write is consumed without enabling the bank
    always_comb begin
        we_d   = 1'b0;
        dest_d = dest_q;
        data_d = data_q;
        if (|grant) begin
            we_d   = (win_addr != '0);
            dest_d = win_addr;
            data_d = win_data;
        end
    end

    // Output register driving the bank's write port
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            we_q   <= 1'b0;
            dest_q <= '0;
            data_q <= '0;
        end else begin
            we_q   <= we_d;
            dest_q <= dest_d;
            data_q <= data_d;
        end
    end

    assign WRITE_ENABLE    = we_q;
    assign DESTINATION_REG = dest_q;
    assign DATA_IN         = data_q;

    // Hazard: a source register matches any pending request or the in-flight write
    always_comb begin
        match1 = we_q && (dest_q == SOURCE_REG1);
        match2 = we_q && (dest_q == SOURCE_REG2);
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (REQ_VALID[i] && (REQ_ADDR[i*REG_ADDR_LEN +: REG_ADDR_LEN] == SOURCE_REG1))
                match1 = 1'b1;
            if (REQ_VALID[i] && (REQ_ADDR[i*REG_ADDR_LEN +: REG_ADDR_LEN] == SOURCE_REG2))
                match2 = 1'b1;
        end
        HAZARD1 = (SOURCE_REG1 != '0) && match1;
        HAZARD2 = (SOURCE_REG2 != '0) && match2;
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed testbench for wb_write_arbiter with a register bank model that
// commits on the falling edge. The expected grant orders follow WB_ARB_RR_EN.
module tb_wb_write_arbiter;

    logic        CLK;
    logic        RESET;
    logic [2:0]  REQ_VALID;
    logic [14:0] REQ_ADDR;
    logic [95:0] REQ_DATA;
    logic [2:0]  REQ_READY;
    logic [4:0]  SOURCE_REG1, SOURCE_REG2;
    logic        WRITE_ENABLE;
    logic [4:0]  DESTINATION_REG;
    logic [31:0] DATA_IN;
    logic        HAZARD1, HAZARD2;

    logic [4:0]  a0, a1, a2;
    logic [31:0] d0, d1, d2;
    logic [31:0] rf [32];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    assign REQ_ADDR = {a2, a1, a0};
    assign REQ_DATA = {d2, d1, d0};

    wb_write_arbiter dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .REQ_VALID       (REQ_VALID),
        .REQ_ADDR        (REQ_ADDR),
        .REQ_DATA        (REQ_DATA),
        .REQ_READY       (REQ_READY),
        .SOURCE_REG1     (SOURCE_REG1),
        .SOURCE_REG2     (SOURCE_REG2),
        .WRITE_ENABLE    (WRITE_ENABLE),
        .DESTINATION_REG (DESTINATION_REG),
        .DATA_IN         (DATA_IN),
        .HAZARD1         (HAZARD1),
        .HAZARD2         (HAZARD2)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Register bank model: commits on the falling edge
    always @(negedge CLK) begin
        if (WRITE_ENABLE) rf[DESTINATION_REG] <= DATA_IN;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    int unsigned order [6];
    int unsigned n_order;
    logic [31:0] last_data;

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        RESET = 1'b1; REQ_VALID = '0;
        a0 = '0; a1 = '0; a2 = '0; d0 = '0; d1 = '0; d2 = '0;
        SOURCE_REG1 = '0; SOURCE_REG2 = '0;

        // Reset state
        #2;
        check("rst_we",   32'(WRITE_ENABLE), 32'd0);
        check("rst_dest", 32'(DESTINATION_REG), 32'd0);
        check("rst_data", DATA_IN, 32'd0);
        REQ_VALID = 3'b111;
        #1 check("rst_ready_held", 32'(REQ_READY), 32'd0);
        REQ_VALID = '0;
        @(negedge CLK) RESET = 1'b0;

        // Single write from requester 0
        @(negedge CLK);
        a0 = 5'd5; d0 = 32'hDEADBEEF; REQ_VALID = 3'b001;
        #1 check("sw_ready", 32'(REQ_READY), 32'b001);
        @(posedge CLK); #1;
        REQ_VALID = '0;
        check("sw_we",   32'(WRITE_ENABLE), 32'd1);
        check("sw_dest", 32'(DESTINATION_REG), 32'd5);
        check("sw_data", DATA_IN, 32'hDEADBEEF);
        @(negedge CLK); #1;
        check("sw_rf5", rf[5], 32'hDEADBEEF);

        // Asynchronous reset mid-cycle while a write is in flight
        a1 = 5'd9; d1 = 32'h55; REQ_VALID = 3'b010;
        #1 check("ar_ready", 32'(REQ_READY), 32'b010);
        @(posedge CLK); #1;
        check("ar_we_pre", 32'(WRITE_ENABLE), 32'd1);
        a2 = 5'd12; d2 = 32'h77; REQ_VALID = 3'b100;
        #1 RESET = 1'b1;
        #1;
        check("ar_we",    32'(WRITE_ENABLE), 32'd0);
        check("ar_dest",  32'(DESTINATION_REG), 32'd0);
        check("ar_data",  DATA_IN, 32'd0);
        check("ar_ready0", 32'(REQ_READY), 32'd0);
        @(posedge CLK); #1;
        check("ar_ready_hold", 32'(REQ_READY), 32'd0);
        check("ar_we_hold",    32'(WRITE_ENABLE), 32'd0);
        @(negedge CLK) RESET = 1'b0;
        #1 check("ar_rearb_ready", 32'(REQ_READY), 32'b100);
        @(posedge CLK); #1;
        REQ_VALID = '0;
        check("ar_rearb_dest", 32'(DESTINATION_REG), 32'd12);
        check("ar_rearb_data", DATA_IN, 32'h77);

        // Contention: all three valid (pointer is back at 0 after the grant to 2)
        @(negedge CLK);
        a0 = 5'd10; d0 = 32'hA0; a1 = 5'd11; d1 = 32'hA1; a2 = 5'd12; d2 = 32'hA2;
        REQ_VALID = 3'b111;
`ifdef WB_ARB_RR_EN
        order = '{0, 1, 2, 0, 1, 2}; n_order = 6;
`else
        order = '{1, 0, 2, 0, 0, 0}; n_order = 3;
`endif
        for (int unsigned k = 0; k < n_order; k++) begin
            #1 check($sformatf("ct_ready%0d", k), 32'(REQ_READY), 32'(1 << order[k]));
            @(posedge CLK); #1;
            check($sformatf("ct_dest%0d", k), 32'(DESTINATION_REG), 32'd10 + order[k]);
`ifndef WB_ARB_RR_EN
            REQ_VALID[order[k]] = 1'b0;
`endif
            @(negedge CLK);
        end
        REQ_VALID = '0;

        // $zero write from requester 2
        a2 = 5'd0; d2 = 32'h1234; REQ_VALID = 3'b100;
        #1 check("z_ready", 32'(REQ_READY), 32'b100);
        @(posedge CLK); #1;
        REQ_VALID = '0;
        check("z_we",   32'(WRITE_ENABLE), 32'd0);
        check("z_data", DATA_IN, 32'h1234);
        @(negedge CLK); #1;
        check("z_rf0", rf[0], 32'd0);

        // Hazard from a pending request, then from the output register
        a1 = 5'd7; d1 = 32'h99; REQ_VALID = 3'b010; SOURCE_REG1 = 5'd7; SOURCE_REG2 = 5'd0;
        #1;
        check("hz_pend1", 32'(HAZARD1), 32'd1);
        check("hz_pend2", 32'(HAZARD2), 32'd0);
        @(posedge CLK); #1;
        REQ_VALID = '0;
        #1;
        check("hz_inflight_we", 32'(WRITE_ENABLE), 32'd1);
        check("hz_inflight1",   32'(HAZARD1), 32'd1);
        @(posedge CLK); #1;
        check("hz_clear1", 32'(HAZARD1), 32'd0);
        SOURCE_REG1 = '0;

        // Back-to-back writes to the same address; reset first so the pointer is 0
        @(negedge CLK);
        RESET = 1'b1; #1 RESET = 1'b0;
        a0 = 5'd3; d0 = 32'h11; a1 = 5'd3; d1 = 32'h22; REQ_VALID = 3'b011;
`ifdef WB_ARB_RR_EN
        order[0] = 0; order[1] = 1; last_data = 32'h22;
`else
        order[0] = 1; order[1] = 0; last_data = 32'h11;
`endif
        for (int unsigned k = 0; k < 2; k++) begin
            #1 check($sformatf("bb_ready%0d", k), 32'(REQ_READY), 32'(1 << order[k]));
            @(posedge CLK); #1;
            check($sformatf("bb_data%0d", k), DATA_IN, (order[k] == 0) ? 32'h11 : 32'h22);
            check($sformatf("bb_we%0d", k), 32'(WRITE_ENABLE), 32'd1);
            REQ_VALID[order[k]] = 1'b0;
            @(negedge CLK);
        end
        #1 check("bb_rf3", rf[3], last_data);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
